// File: rtl/pc_fetch_sequencer.sv
// Program counter sequencer: chooses the next PC, fetches it from instruction memory
// over a req/ack handshake, and holds the presented instruction while the pipeline stalls.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

    localparam int unsigned   CW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   next_pc;

    assign pc_plus4  = pc_out + 32'd4;
    assign imem_addr = pc_out;

    always_comb begin
        next_pc = pc_plus4;
        if (jr)
            next_pc = jr_addr;
        else if (jump)
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        else if (branch_taken)
            next_pc = pc_plus4 + (branch_offset << 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_out      <= RESET_ADDR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                end
                REQ: begin
                    // ack is tested first so it wins over a timeout on the same edge
                    if (imem_ack) begin
                        state       <= VALID;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        wait_cnt    <= '0;
                    end else if (wait_cnt == LAST) begin
                        state     <= ERR;
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                VALID: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            state     <= ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            state    <= REQ;
                            pc_out   <= next_pc;
                            imem_req <= 1'b1;
                            wait_cnt <= '0;
                        end
                    end
                end
                ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: redirect table plus handshake, stall,
// timeout, misalignment and asynchronous reset sequences.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    pc_fetch_sequencer #(.RESET_ADDR(32'h0000_0000), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start_pc;
        logic        br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] tgt;
        logic        jreg;
        logic [31:0] jaddr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", {31'b0, imem_req}, 32'd1);
    endtask

    // Called at a negedge while in REQ; returns at the negedge in VALID.
    task automatic do_ack();
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("ack_valid", {31'b0, instr_valid}, 32'd1);
        check("ack_req_low", {31'b0, imem_req}, 32'd0);
    endtask

    // Called in VALID; jump-registers to target and returns at the first REQ negedge.
    task automatic go_to(input logic [31:0] target);
        jr = 1'b1;
        jr_addr = target;
        @(negedge clk);
        jr = 1'b0;
        check("goto_addr", imem_addr, target);
    endtask

    initial begin
        vecs[0] = '{32'h10, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0C};
        vecs[1] = '{32'h10, 1'b1, 32'hFFFF_FFFE, 1'b1, 26'h40, 1'b0, 32'h0, 32'h100};
        vecs[2] = '{32'h10, 1'b1, 32'hFFFF_FFFE, 1'b1, 26'h40, 1'b1, 32'h200, 32'h200};
        vecs[3] = '{32'h10, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h14};
        vecs[4] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{32'h1000, 1'b1, 32'h10, 1'b0, 26'h0, 1'b0, 32'h0, 32'h1044};
        vecs[6] = '{32'hF000_0000, 1'b0, 32'h0, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0, 32'hFFFF_FFFC};
        vecs[7] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 26'h1, 1'b0, 32'h0, 32'h4};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        check("rst_pc", pc_out, 32'h0);
        rst_n = 1'b1;

        // first fetch: ack on the third REQ cycle
        wait_req();
        check("f1_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("f1_req2", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        check("f1_req3", {31'b0, imem_req}, 32'd1);
        check("f1_err3", {31'b0, fetch_err}, 32'd0);
        do_ack();
        check("f1_pc", pc_out, 32'h0);
        check("f1_plus4", pc_plus4, 32'h4);
        @(negedge clk);
        check("f1_valid_drop", {31'b0, instr_valid}, 32'd0);
        check("f1_next_req", {31'b0, imem_req}, 32'd1);
        check("f1_next_addr", imem_addr, 32'h4);

        // redirect table
        for (int i = 0; i < 8; i++) begin
            do_ack();
            go_to(vecs[i].start_pc);
            do_ack();
            check("vec_pc", pc_out, vecs[i].start_pc);
            check("vec_plus4", pc_plus4, vecs[i].start_pc + 32'd4);
            branch_taken  = vecs[i].br;
            branch_offset = vecs[i].off;
            jump          = vecs[i].jmp;
            jump_target   = vecs[i].tgt;
            jr            = vecs[i].jreg;
            jr_addr       = vecs[i].jaddr;
            @(negedge clk);
            branch_taken = 1'b0;
            jump = 1'b0;
            jr = 1'b0;
            check("vec_addr", imem_addr, vecs[i].exp_addr);
            check("vec_req", {31'b0, imem_req}, 32'd1);
        end

        // stall for three cycles with a redirect that must be ignored
        do_ack();
        stall = 1'b1;
        jr = 1'b1;
        jr_addr = 32'h300;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_pc", pc_out, 32'h4);
            check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        jr = 1'b0;
        @(negedge clk);
        check("unstall_addr", imem_addr, 32'h8);
        check("unstall_req", {31'b0, imem_req}, 32'd1);

        // timeout: four REQ cycles without ack, then sticky error
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("to_req", {31'b0, imem_req}, 32'd1);
        end
        @(negedge clk);
        check("to_err", {31'b0, fetch_err}, 32'd1);
        check("to_req_low", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        check("to_err_hold", {31'b0, fetch_err}, 32'd1);
        check("to_valid_low", {31'b0, instr_valid}, 32'd0);
        check("to_pc_hold", pc_out, 32'h8);

        // ack on the same edge as the timeout wins
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_req();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("race_req4", {31'b0, imem_req}, 32'd1);
        do_ack();
        check("race_no_err", {31'b0, fetch_err}, 32'd0);
        go_to(32'h40);
        do_ack();
        @(negedge clk);
        check("pre_rst_addr", imem_addr, 32'h44);

        // asynchronous reset mid-REQ
        rst_n = 1'b0;
        #1;
        check("async_req", {31'b0, imem_req}, 32'd0);
        check("async_pc", pc_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // misaligned jr target
        wait_req();
        do_ack();
        jr = 1'b1;
        jr_addr = 32'h102;
        @(negedge clk);
        jr = 1'b0;
        check("mis_err", {31'b0, fetch_err}, 32'd1);
        check("mis_pc", pc_out, 32'h0);
        check("mis_req", {31'b0, imem_req}, 32'd0);
        check("mis_valid", {31'b0, instr_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
